id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning datapath width of operand and immediate fields.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of bubble_count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_valid  input  1  decode slot holds a real instruction.
REQ-006 SHALL have ports id_Rn, id_Rm, id_Rd  input  5 each  decoded register numbers.
REQ-007 SHALL have ports id_ReadData1, id_ReadData2, id_Imm  input  WIDTH each  regfile read ports and sign-extended immediate.
REQ-008 SHALL have ports id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc  input  1 each  decoded control.
REQ-009 SHALL have port id_ALUOp  input  3  ALU operation code.
REQ-010 SHALL have port flush  input  1  squash decode-slot instruction (taken branch).
REQ-011 SHALL have port ex_hold  input  1  downstream stall; hold stage contents.
REQ-012 SHALL have ex_valid, ex_Rn, ex_Rm, ex_Rd, ex_ReadData1, ex_ReadData2, ex_Imm, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_ALUOp  output  widths matching id_* counterparts  registered stage contents.
REQ-013 SHALL have port stall_upstream  output  1  combinational; PC and IF/ID hold this cycle.
REQ-014 SHALL have port bubble_count  output  CNT_WIDTH  count of inserted load-use bubbles.

Function
REQ-015 hazard SHALL be ex_valid & ex_MemRead & id_valid & ~flush & (ex_Rd != 31) & ((ex_Rd == id_Rn) | (ex_Rd == id_Rm)).
REQ-016 stall_upstream SHALL equal ex_hold | hazard, same cycle, no register.
REQ-017 Per edge, priority SHALL be flush > ex_hold > hazard > load.
REQ-018 flush: ex_valid and all six control outputs (incl. ex_ALUOp) SHALL become 0; data/register fields SHALL hold.
REQ-019 ex_hold (no flush): every output register SHALL hold its value.
REQ-020 hazard (no flush, no ex_hold): bubble -- ex_valid and control outputs SHALL become 0, data fields hold; bubble_count SHALL increment by 1.
REQ-021 load: all ex_* SHALL capture id_* one cycle after the edge (latency 1); if id_valid=0, controls SHALL load as 0 and ex_valid as 0.
REQ-022 A bubble SHALL last exactly one cycle: after it ex_MemRead=0, so the held instruction loads on the next edge absent ex_hold/flush.
REQ-023 Register 31 SHALL never trigger hazard (always-zero register).
REQ-024 bubble_count SHALL saturate at all-ones, no wrap.
REQ-025 flush with simultaneous hazard SHALL insert no bubble counted and SHALL deassert hazard-driven stall.
REQ-026 ex_hold with simultaneous hazard SHALL not increment bubble_count; hazard re-evaluates next cycle.

Reset
REQ-027 While reset=1, asynchronously: ex_valid=0, all controls=0, ex_ALUOp=0, ex_Rn=ex_Rm=ex_Rd=31, data fields=0, bubble_count=0.
REQ-028 Reset asserted mid-stall SHALL abandon the stall; stall_upstream then equals ex_hold only (hazard=0 since ex_valid=0).
REQ-029 First load edge after reset deassertion SHALL behave per REQ-021.

Configuration
REQ-030 Macro LOAD_USE_DETECT_EN SHALL control hazard logic.
REQ-031 Defined: behaviour per REQ-015..REQ-026.
REQ-032 Undefined: hazard SHALL be constant 0, stall_upstream = ex_hold, bubble_count constant 0; no bubbles ever inserted (compiler schedules load delay).

Verification
REQ-033 Reset then id_valid=1, id_Rd=5, id_ReadData1=64'h1234, id_RegWrite=1, one edge -> ex_valid=1, ex_Rd=5, ex_ReadData1=64'h1234, ex_RegWrite=1, stall_upstream=0.
REQ-034 EX holds LDUR ex_Rd=3, ex_MemRead=1; ID has id_Rn=3 -> stall_upstream=1; next edge ex_valid=0, controls 0, bubble_count=1; following edge ID instruction loads, stall_upstream=0.
REQ-035 EX holds load ex_Rd=31; ID id_Rm=31 -> stall_upstream=0, no bubble, bubble_count unchanged.
REQ-036 Hazard present with flush=1 -> stall_upstream=0; next edge ex_valid=0, bubble_count unchanged.
REQ-037 ex_hold=1 for 3 cycles with changing id_* -> ex_* unchanged, stall_upstream=1 all 3 cycles; release -> id_* captured.
REQ-038 Preload bubble_count to all-ones via repeated hazards, one more hazard -> bubble_count stays 16'hFFFF; with LOAD_USE_DETECT_EN undefined, REQ-034 stimulus -> no stall, bubble_count=0.

Source files
------------

// File: rtl/id_ex_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register with load-use hazard detection
//
// Captures the decoded instruction (register numbers, operands, immediate and
// control bits) from the decode slot into the execute slot. When the execute
// slot holds a load whose destination feeds the decode instruction, a single
// bubble is inserted and the upstream stages are told to hold.
//
// Optional feature macro: LOAD_USE_DETECT_EN
//   defined   : load-use hazard detection, bubble insertion, bubble_count.
//   undefined : no hazard logic; stall_upstream = ex_hold, bubble_count = 0.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   id_valid            decode slot holds a real instruction
//   id_Rn/Rm/Rd         decoded register numbers (5 bits)
//   id_ReadData1/2      register file read data (WIDTH)
//   id_Imm              sign-extended immediate (WIDTH)
//   id_RegWrite..ALUSrc decoded control bits; id_ALUOp 3-bit ALU op
//   flush               squash the decode-slot instruction (taken branch)
//   ex_hold             downstream stall; hold the stage contents
//   ex_*                registered stage contents
//   stall_upstream      combinational; PC and IF/ID must hold this cycle
//   bubble_count        saturating count of inserted load-use bubbles
//
// Handshake: the decode slot offers an instruction whenever id_valid=1; it is
// consumed on a rising edge only when stall_upstream=0 and flush=0. While
// stall_upstream=1 the producer must keep the same instruction presented.
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [4:0]           id_Rn,
    input  logic [4:0]           id_Rm,
    input  logic [4:0]           id_Rd,
    input  logic [WIDTH-1:0]     id_ReadData1,
    input  logic [WIDTH-1:0]     id_ReadData2,
    input  logic [WIDTH-1:0]     id_Imm,
    input  logic                 id_RegWrite,
    input  logic                 id_MemRead,
    input  logic                 id_MemWrite,
    input  logic                 id_MemToReg,
    input  logic                 id_ALUSrc,
    input  logic [2:0]           id_ALUOp,
    input  logic                 flush,
    input  logic                 ex_hold,
    output logic                 ex_valid,
    output logic [4:0]           ex_Rn,
    output logic [4:0]           ex_Rm,
    output logic [4:0]           ex_Rd,
    output logic [WIDTH-1:0]     ex_ReadData1,
    output logic [WIDTH-1:0]     ex_ReadData2,
    output logic [WIDTH-1:0]     ex_Imm,
    output logic                 ex_RegWrite,
    output logic                 ex_MemRead,
    output logic                 ex_MemWrite,
    output logic                 ex_MemToReg,
    output logic                 ex_ALUSrc,
    output logic [2:0]           ex_ALUOp,
    output logic                 stall_upstream,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic hazard;

`ifdef LOAD_USE_DETECT_EN
    // A load in EX whose destination is a source of the ID instruction.
    // Register 31 reads as zero, so it never creates a dependency. A flush
    // squashes the ID instruction, so its dependency no longer matters.
    assign hazard = ex_valid & ex_MemRead & id_valid & ~flush
                  & (ex_Rd != ZERO_REG)
                  & ((ex_Rd == id_Rn) | (ex_Rd == id_Rm));
`else
    assign hazard = 1'b0;
`endif

    assign stall_upstream = ex_hold | hazard;

    // Priority per edge: flush > ex_hold > hazard > load.
    // Flush and bubble both kill the instruction (valid/controls) but leave
    // the data fields untouched; the bubble clears ex_MemRead, so the hazard
    // cannot persist beyond one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_MemToReg  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= 3'b000;
            ex_Rn        <= ZERO_REG;
            ex_Rm        <= ZERO_REG;
            ex_Rd        <= ZERO_REG;
            ex_ReadData1 <= '0;
            ex_ReadData2 <= '0;
            ex_Imm       <= '0;
        end else if (flush || (!ex_hold && hazard)) begin
            ex_valid     <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_MemToReg  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= 3'b000;
        end else if (!ex_hold) begin
            // An empty decode slot loads as a clean no-op.
            ex_valid     <= id_valid;
            ex_RegWrite  <= id_valid & id_RegWrite;
            ex_MemRead   <= id_valid & id_MemRead;
            ex_MemWrite  <= id_valid & id_MemWrite;
            ex_MemToReg  <= id_valid & id_MemToReg;
            ex_ALUSrc    <= id_valid & id_ALUSrc;
            ex_ALUOp     <= id_valid ? id_ALUOp : 3'b000;
            ex_Rn        <= id_Rn;
            ex_Rm        <= id_Rm;
            ex_Rd        <= id_Rd;
            ex_ReadData1 <= id_ReadData1;
            ex_ReadData2 <= id_ReadData2;
            ex_Imm       <= id_Imm;
        end
    end

`ifdef LOAD_USE_DETECT_EN
    // Counts only bubbles actually inserted; saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!flush && !ex_hold && hazard && (bubble_count != '1)) begin
            bubble_count <= bubble_count + CNT_WIDTH'(1);
        end
    end
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
`timescale 1ns/1ps
module tb_id_ex_reg;

    localparam int WIDTH = 64;
    localparam int CW    = 4;   // narrow counter so saturation is reachable quickly
    localparam int SW    = 1 + 15 + 3 * WIDTH + 8 + CW;
    localparam logic [63:0] IMM_K = 64'h5A5A_5A5A_0F0F_F0F0;

`ifdef LOAD_USE_DETECT_EN
    localparam bit D = 1'b1;
`else
    localparam bit D = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             id_valid;
    logic [4:0]       id_Rn, id_Rm, id_Rd;
    logic [WIDTH-1:0] id_ReadData1, id_ReadData2, id_Imm;
    logic             id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc;
    logic [2:0]       id_ALUOp;
    logic             flush, ex_hold;
    logic             ex_valid;
    logic [4:0]       ex_Rn, ex_Rm, ex_Rd;
    logic [WIDTH-1:0] ex_ReadData1, ex_ReadData2, ex_Imm;
    logic             ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc;
    logic [2:0]       ex_ALUOp;
    logic             stall_upstream;
    logic [CW-1:0]    bubble_count;

    id_ex_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2), .id_Imm(id_Imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .ex_Rd(ex_Rd),
        .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2), .ex_Imm(ex_Imm),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemToReg(ex_MemToReg), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .stall_upstream(stall_upstream), .bubble_count(bubble_count)
    );

    // ---------------- vectors ----------------
    // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]}
    localparam logic [7:0] ADD  = 8'h82;
    localparam logic [7:0] LDUR = 8'hD8;

    typedef struct {
        logic        valid;
        logic [4:0]  rn, rm, rd;
        logic [63:0] rd1;
        logic [7:0]  ctrl;
        logic        flush, hold;
        logic        e_stall, e_valid;
        logic [4:0]  e_rn, e_rm, e_rd;
        logic [63:0] e_rd1;
        logic [7:0]  e_ctrl;
        logic [CW-1:0] e_bc;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic [4:0] rn, input logic [4:0] rm,
                                input logic [4:0] rd, input logic [63:0] rd1, input logic [7:0] ctrl,
                                input logic fl, input logic hd, input logic e_stall, input logic e_valid,
                                input logic [4:0] e_rn, input logic [4:0] e_rm, input logic [4:0] e_rd,
                                input logic [63:0] e_rd1, input logic [7:0] e_ctrl, input logic [CW-1:0] e_bc);
        vec_t v;
        v.valid = valid; v.rn = rn; v.rm = rm; v.rd = rd; v.rd1 = rd1; v.ctrl = ctrl;
        v.flush = fl; v.hold = hd; v.e_stall = e_stall; v.e_valid = e_valid;
        v.e_rn = e_rn; v.e_rm = e_rm; v.e_rd = e_rd; v.e_rd1 = e_rd1;
        v.e_ctrl = e_ctrl; v.e_bc = e_bc;
        return v;
    endfunction

    function automatic logic [SW-1:0] pack(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                                           input logic [63:0] imm, input logic [7:0] ctrl, input logic [CW-1:0] bc);
        return {v, rn, rm, rd, d1, d2, imm, ctrl, bc};
    endfunction

    // ---------------- scoreboard ----------------
    logic [SW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [SW-1:0] actual_state();
        return pack(ex_valid, ex_Rn, ex_Rm, ex_Rd, ex_ReadData1, ex_ReadData2, ex_Imm,
                    {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_ALUOp},
                    bubble_count);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [SW-1:0] exp);
        logic [SW-1:0] act;
        act = actual_state();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s state: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_id(input vec_t v);
        id_valid = v.valid; id_Rn = v.rn; id_Rm = v.rm; id_Rd = v.rd;
        id_ReadData1 = v.rd1; id_ReadData2 = ~v.rd1; id_Imm = v.rd1 ^ IMM_K;
        {id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_ALUOp} = v.ctrl;
        flush = v.flush; ex_hold = v.hold;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        drive_id(v);
        #1;
        check_bit({name, " stall"}, stall_upstream, v.e_stall);
        exp_q.push_back(pack(v.e_valid, v.e_rn, v.e_rm, v.e_rd, v.e_rd1, ~v.e_rd1,
                             v.e_rd1 ^ IMM_K, v.e_ctrl, v.e_bc));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_state(name, exp_q.pop_front());
        end
    endtask

    vec_t tbl[17];
    logic [SW-1:0] reset_state;
    int bc_exp;

    initial begin
        reset = 1'b1;
        drive_id(mk(0, 0, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 8'h0, 0));
        reset_state = pack(1'b0, 5'd31, 5'd31, 5'd31, 64'h0, 64'h0, 64'h0, 8'h0, '0);

        tbl[0]  = mk(1, 1, 2, 5, 64'h1234, ADD, 0, 0, 0, 1, 1, 2, 5, 64'h1234, ADD, 0);
        tbl[1]  = mk(1, 4, 6, 3, 64'hA0, LDUR, 0, 0, 0, 1, 4, 6, 3, 64'hA0, LDUR, 0);
        tbl[2]  = mk(1, 3, 7, 8, 64'hB0, ADD, 0, 0, D, !D, D ? 5'd4 : 5'd3, D ? 5'd6 : 5'd7,
                     D ? 5'd3 : 5'd8, D ? 64'hA0 : 64'hB0, D ? 8'h0 : ADD, D ? 4'd1 : 4'd0);
        tbl[3]  = mk(1, 3, 7, 8, 64'hB0, ADD, 0, 0, 0, 1, 3, 7, 8, 64'hB0, ADD, D ? 4'd1 : 4'd0);
        tbl[4]  = mk(1, 9, 10, 31, 64'hC0, LDUR, 0, 0, 0, 1, 9, 10, 31, 64'hC0, LDUR, D ? 4'd1 : 4'd0);
        tbl[5]  = mk(1, 31, 31, 12, 64'hD0, ADD, 0, 0, 0, 1, 31, 31, 12, 64'hD0, ADD, D ? 4'd1 : 4'd0);
        tbl[6]  = mk(1, 1, 2, 4, 64'hE0, LDUR, 0, 0, 0, 1, 1, 2, 4, 64'hE0, LDUR, D ? 4'd1 : 4'd0);
        tbl[7]  = mk(1, 13, 4, 14, 64'hF0, ADD, 1, 0, 0, 0, 1, 2, 4, 64'hE0, 8'h0, D ? 4'd1 : 4'd0);
        tbl[8]  = mk(1, 0, 0, 6, 64'h100, LDUR, 0, 0, 0, 1, 0, 0, 6, 64'h100, LDUR, D ? 4'd1 : 4'd0);
        tbl[9]  = mk(1, 6, 1, 7, 64'h110, ADD, 0, 1, 1, 1, 0, 0, 6, 64'h100, LDUR, D ? 4'd1 : 4'd0);
        tbl[10] = mk(1, 6, 5, 9, 64'h120, ADD, 0, 1, 1, 1, 0, 0, 6, 64'h100, LDUR, D ? 4'd1 : 4'd0);
        tbl[11] = mk(1, 2, 3, 10, 64'h130, ADD, 0, 1, 1, 1, 0, 0, 6, 64'h100, LDUR, D ? 4'd1 : 4'd0);
        tbl[12] = mk(1, 6, 1, 7, 64'h110, ADD, 0, 0, D, !D, D ? 5'd0 : 5'd6, D ? 5'd0 : 5'd1,
                     D ? 5'd6 : 5'd7, D ? 64'h100 : 64'h110, D ? 8'h0 : ADD, D ? 4'd2 : 4'd0);
        tbl[13] = mk(1, 6, 1, 7, 64'h110, ADD, 0, 0, 0, 1, 6, 1, 7, 64'h110, ADD, D ? 4'd2 : 4'd0);
        tbl[14] = mk(0, 1, 1, 1, 64'h140, LDUR, 0, 0, 0, 0, 1, 1, 1, 64'h140, 8'h0, D ? 4'd2 : 4'd0);
        tbl[15] = mk(1, 2, 2, 5, 64'h150, LDUR, 0, 0, 0, 1, 2, 2, 5, 64'h150, LDUR, D ? 4'd2 : 4'd0);
        tbl[16] = mk(0, 5, 5, 5, 64'h160, ADD, 0, 0, 0, 0, 5, 5, 5, 64'h160, 8'h0, D ? 4'd2 : 4'd0);

        // reset state, checked while reset is still asserted
        #1;
        check_state("reset", reset_state);
        check_bit("reset stall", stall_upstream, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // reset asserted in the middle of a load-use stall
        apply_vec(mk(1, 0, 0, 3, 64'h170, LDUR, 0, 0, 0, 1, 0, 0, 3, 64'h170, LDUR, D ? 4'd2 : 4'd0),
                  "pre_reset_load");
        @(negedge clk);
        drive_id(mk(1, 3, 9, 9, 64'h180, ADD, 0, 0, 0, 0, 0, 0, 0, 64'h0, 8'h0, 0));
        #1;
        check_bit("midstall stall", stall_upstream, D);
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", reset_state);
        check_bit("reset abandons stall", stall_upstream, 1'b0);
        ex_hold = 1'b1;
        #1;
        check_bit("reset stall follows hold", stall_upstream, 1'b1);
        @(negedge clk);
        ex_hold = 1'b0;
        reset = 1'b0;

        // first load after reset release
        apply_vec(mk(1, 1, 2, 11, 64'h400, ADD, 0, 0, 0, 1, 1, 2, 11, 64'h400, ADD, 0), "first_load");

        // repeated hazards until the counter saturates, then one more
        bc_exp = 0;
        for (int i = 1; i <= 16; i++) begin
            apply_vec(mk(1, 0, 0, 3, 64'h200 + 64'(i), LDUR, 0, 0, 0, 1, 0, 0, 3, 64'h200 + 64'(i),
                         LDUR, CW'(bc_exp)), $sformatf("sat_load%0d", i));
            if (D) begin
                if (bc_exp < 15) bc_exp++;
                apply_vec(mk(1, 3, 8, 9, 64'h300 + 64'(i), ADD, 0, 0, 1, 0, 0, 0, 3, 64'h200 + 64'(i),
                             8'h0, CW'(bc_exp)), $sformatf("sat_bubble%0d", i));
            end else begin
                apply_vec(mk(1, 3, 8, 9, 64'h300 + 64'(i), ADD, 0, 0, 0, 1, 3, 8, 9, 64'h300 + 64'(i),
                             ADD, CW'(0)), $sformatf("sat_nohaz%0d", i));
            end
        end
        checks++;
        if (bubble_count !== (D ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL saturation: got %h expected %h", bubble_count, D ? 4'hF : 4'h0);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
